gf_mul_seq: RTL

//  Multi-lane sequential GF(2^WIDTH) multiplier: p = a*b mod POLY per lane, all lanes in lockstep.

---
 rtl/gf_mul_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gf_mul_seq.sv
// -----------------------------------------------------------------------------
// gf_mul_seq
//   Multi-lane sequential GF(2^WIDTH) multiplier. Each lane computes
//   p = a*b mod POLY with a shift-and-add loop that consumes BITS_PER_CYCLE
//   bits of b per RUN cycle, LSB first. All lanes share one control FSM and
//   run in lockstep.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The producer holds its data and valid stable until that edge; the
//   consumer may change ready freely. in_ready is high only in IDLE, out_valid
//   is high only in DONE, and p stays stable while out_valid=1 && out_ready=0.
//
//   Optional feature (macro GF_MUL_EARLY_DONE_EN): once the remaining b bits
//   are zero in every lane, the FSM leaves RUN early. Results are unchanged;
//   only latency varies. Without the macro the latency is fixed at
//   WIDTH/BITS_PER_CYCLE+1 edges from accept to out_valid.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   in_valid   in   1            a/b operands valid
//   in_ready   out  1            block can accept operands (IDLE only)
//   a          in   LANES*WIDTH  multiplicand, lane i = a[i*WIDTH +: WIDTH]
//   b          in   LANES*WIDTH  multiplier, same packing
//   out_valid  out  1            p holds a finished product (DONE only)
//   out_ready  in   1            consumer takes p
//   p          out  LANES*WIDTH  product, same packing
//   busy       out  1            FSM in RUN or DONE
//   dbg_state  out  2            current FSM state (0=IDLE,1=RUN,2=DONE)
// -----------------------------------------------------------------------------
module gf_mul_seq #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH:0]   POLY           = 9'h11D,
  parameter int               LANES          = 4,
  parameter int               BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   a,
  input  logic [LANES*WIDTH-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   p,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic [LANES*WIDTH-1:0] r_p;
  logic [CW-1:0]          r_cnt;
  // Set once the last step has been applied; RUN then spends one more cycle
  // handing acc over to p on the way into DONE.
  logic                   r_fin;

  logic [WIDTH-1:0] r_sh_a [LANES];
  logic [WIDTH-1:0] r_sh_b [LANES];
  logic [WIDTH-1:0] r_acc  [LANES];

  logic [WIDTH-1:0] w_sh_a_nx [LANES];
  logic [WIDTH-1:0] w_sh_b_nx [LANES];
  logic [WIDTH-1:0] w_acc_nx  [LANES];
  logic             w_fin_nx;
`ifdef GF_MUL_EARLY_DONE_EN
  logic             w_any_b;
`endif

  // Multiply by x modulo POLY: shift left, fold the overflow bit back in.
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
  endfunction

  // One RUN step per lane: BITS_PER_CYCLE unrolled shift-and-add iterations.
  always_comb begin
    logic [WIDTH-1:0] ta, tb, tacc;
    ta   = '0;
    tb   = '0;
    tacc = '0;
`ifdef GF_MUL_EARLY_DONE_EN
    w_any_b = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      ta   = r_sh_a[l];
      tb   = r_sh_b[l];
      tacc = r_acc[l];
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
        if (tb[0]) tacc = tacc ^ ta;
        ta = xtime(ta);
        tb = tb >> 1;
      end
      w_sh_a_nx[l] = ta;
      w_sh_b_nx[l] = tb;
      w_acc_nx[l]  = tacc;
`ifdef GF_MUL_EARLY_DONE_EN
      w_any_b = w_any_b | (|tb);
`endif
    end
  end

`ifdef GF_MUL_EARLY_DONE_EN
  // Remaining multiplier bits all zero: further steps cannot change acc.
  assign w_fin_nx = (r_cnt == LAST_STEP) || !w_any_b;
`else
  assign w_fin_nx = (r_cnt == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_fin       <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_sh_a[l] <= '0;
        r_sh_b[l] <= '0;
        r_acc[l]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
          if (in_valid) begin
            for (int l = 0; l < LANES; l++) begin
              r_sh_a[l] <= a[l*WIDTH +: WIDTH];
              r_sh_b[l] <= b[l*WIDTH +: WIDTH];
              r_acc[l]  <= '0;
            end
            r_cnt      <= '0;
            r_fin      <= 1'b0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_fin) begin
            for (int l = 0; l < LANES; l++) begin
              r_p[l*WIDTH +: WIDTH] <= r_acc[l];
            end
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              r_sh_a[l] <= w_sh_a_nx[l];
              r_sh_b[l] <= w_sh_b_nx[l];
              r_acc[l]  <= w_acc_nx[l];
            end
            r_cnt <= r_cnt + 1'b1;
            r_fin <= w_fin_nx;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;
  assign dbg_state = r_state;

endmodule
